seq_divider_16bit: RTL and testbench
====================================

SEQ_DIVIDER_16BIT -- requirements
Module: seq_divider_16bit

Interface
REQ-001 SHALL have no parameters; data widths are fixed at 16 bits.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to begin a division; sampled on the rising edge of clk.
REQ-006 A  input  16  unsigned dividend; sampled when start is accepted.
REQ-007 B  input  16  unsigned divisor; sampled when start is accepted.
REQ-008 Q  output  16  unsigned quotient (registered).
REQ-009 R  output  16  unsigned remainder (registered).
REQ-010 busy  output  1  high while a division is in progress.
REQ-011 done  output  1  one-cycle pulse marking Q and R valid.

Function
REQ-012 SHALL implement an FSM with three states: IDLE, RUN and DONE.
REQ-013 start is accepted only in IDLE or DONE. On acceptance, A and B are captured, the iteration counter is set to 0 and the FSM enters RUN.
REQ-014 start is ignored while in RUN: the captured operands do not change and the running division is not affected.
REQ-015 The datapath is a restoring divider with a 17-bit partial remainder.
- Each RUN cycle shifts the next dividend bit (MSB first) into the partial remainder.
- A trial subtraction of B follows.
- Non-negative result: the difference is kept and quotient bit = 1.
- Negative result: the partial remainder is restored and quotient bit = 0.
REQ-016 RUN SHALL last exactly 16 cycles. After the 16th iteration the FSM enters DONE.
REQ-017 Timing, with start accepted at edge k:
- busy = 1 from edge k through edge k+16.
- done = 1 for exactly the cycle following edge k+16 (latency 17 cycles).
REQ-018 Q and R SHALL update only on the transition into DONE. They hold their values until the next completion or reset.
REQ-019 DONE lasts one cycle, then returns to IDLE. If start is high in DONE, the FSM enters RUN directly and done still pulses for only one cycle.
REQ-020 Divide by zero, base build: the algorithm runs unmodified and yields Q = 0xFFFF and R = A.
REQ-021 The result SHALL satisfy A = Q*B + R, with R < B, for every B != 0.

Reset
REQ-022 rst_n low SHALL asynchronously force:
- the FSM to IDLE;
- Q, R, the partial remainder and the counter to 0;
- busy = 0 and done = 0.
REQ-023 A reset during RUN SHALL abort the division; no done pulse is produced for the aborted operation.
REQ-024 After rst_n deasserts, start is accepted on the first rising edge of clk.

Configuration
REQ-025 Macro DIV_BY_ZERO_FLAG_EN controls divide-by-zero detection.
REQ-026 With DIV_BY_ZERO_FLAG_EN defined:
- Adds output div_zero (1 bit, reset 0).
- If B == 0 when start is accepted at edge k, the FSM goes from RUN to DONE after one cycle: busy is high for one cycle and done pulses in the cycle after edge k+1.
- In that case Q = 0xFFFF, R = A and div_zero = 1.
- div_zero holds with Q and R and clears on the next accepted start.
REQ-027 Without DIV_BY_ZERO_FLAG_EN: no div_zero port exists, and B == 0 follows REQ-020 with the full 17-cycle latency.

Verification
REQ-028 Basic division: A=100, B=7, start pulse -> done exactly 17 cycles after acceptance; Q=14, R=2; busy high for 16 cycles.
REQ-029 Boundary cases:
- A=0xFFFF, B=1 -> Q=0xFFFF, R=0.
- A=5, B=9 -> Q=0, R=5.
- A=0xFFFF, B=0xFFFF -> Q=1, R=0.
REQ-030 Divide by zero, A=0x1234, B=0:
- Base build -> done at 17 cycles, Q=0xFFFF, R=0x1234.
- With DIV_BY_ZERO_FLAG_EN -> done at 2 cycles, same Q and R, div_zero=1.
REQ-031 Start while busy: start A=100, B=7; 5 cycles later, start again with A=9, B=3 -> second start ignored; result Q=14, R=2.
REQ-032 Back-to-back: start A=50, B=6 held high through DONE with A=81, B=9 -> first result Q=8, R=2; second run accepted in the DONE cycle; second result Q=9, R=0 exactly 17 cycles later.
REQ-033 Reset mid-run: assert rst_n low 8 cycles into RUN -> busy, done, Q and R = 0 immediately; no done pulse; a new start after release completes normally.

Source files
------------

// File: rtl/seq_divider_16bit.sv
// Sequential 16-bit unsigned restoring divider: IDLE -> RUN (16 iterations) -> DONE.
// Optional DIV_BY_ZERO_FLAG_EN adds a div_zero output and an early finish when B == 0.
module seq_divider_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] Q,
    output logic [15:0] R,
    output logic        busy,
    output logic        done
`ifdef DIV_BY_ZERO_FLAG_EN
    ,
    output logic        div_zero
`endif
);

    localparam int unsigned W  = 16;
    localparam int unsigned RW = W + 1;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;      // dividend shifts out MSB-first, quotient shifts in at LSB
    logic [W-1:0]    b_q, b_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    q_q, q_d;
    logic [W-1:0]    r_q, r_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef DIV_BY_ZERO_FLAG_EN
    logic            dz_q, dz_d;
    logic            div_zero_q, div_zero_d;
`endif

    logic [RW-1:0]   rem_shift_c;
    logic [RW-1:0]   rem_diff_c;
    logic            q_bit_c;

    // One restoring step: shift in next dividend bit, trial-subtract the divisor.
    always_comb begin
        rem_shift_c = RW'({rem_q, a_q[W-1]});
        rem_diff_c  = rem_shift_c - {1'b0, b_q};
        q_bit_c     = ~rem_diff_c[W];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
`ifdef DIV_BY_ZERO_FLAG_EN
        dz_d       = dz_q;
        div_zero_d = div_zero_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = A;
                    b_d     = B;
                    rem_d   = '0;
                    cnt_d   = '0;
`ifdef DIV_BY_ZERO_FLAG_EN
                    dz_d       = (B == '0);
                    div_zero_d = 1'b0;
`endif
                end
            end

            ST_RUN: begin
`ifdef DIV_BY_ZERO_FLAG_EN
                if (dz_q) begin
                    state_d    = ST_DONE;
                    q_d        = {W{1'b1}};
                    r_d        = a_q;
                    dz_d       = 1'b0;
                    div_zero_d = 1'b1;
                end else begin
`endif
                    a_d   = {a_q[W-2:0], q_bit_c};
                    rem_d = q_bit_c ? rem_diff_c : rem_shift_c;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        state_d = ST_DONE;
                        q_d     = {a_q[W-2:0], q_bit_c};
                        r_d     = q_bit_c ? rem_diff_c[W-1:0] : rem_shift_c[W-1:0];
                    end
`ifdef DIV_BY_ZERO_FLAG_EN
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef DIV_BY_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dz_q       <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            dz_q       <= dz_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign div_zero = div_zero_q;
`endif

    assign Q    = q_q;
    assign R    = r_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_seq_divider_16bit.sv
// Directed testbench for seq_divider_16bit; honours DIV_BY_ZERO_FLAG_EN when defined.
module tb_seq_divider_16bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        busy;
    logic        done;
`ifdef DIV_BY_ZERO_FLAG_EN
    logic        div_zero;
    localparam int ZLAT  = 1;
    localparam int ZBUSY = 1;
`else
    localparam int ZLAT  = 16;
    localparam int ZBUSY = 16;
`endif

    int checks = 0;
    int errors = 0;

    seq_divider_16bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a),
        .B     (b),
        .Q     (q),
        .R     (r),
        .busy  (busy),
`ifdef DIV_BY_ZERO_FLAG_EN
        .div_zero (div_zero),
`endif
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lat = edges after the acceptance edge until done is seen; bcnt = busy samples.
    task automatic run_div(input logic [15:0] av, input logic [15:0] bv,
                           output int lat, output int bcnt);
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        bcnt = busy ? 1 : 0;
        lat  = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (busy) bcnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_div(input string tag, input logic [15:0] av, input logic [15:0] bv,
                             input logic [15:0] eq, input logic [15:0] er,
                             input int elat, input int ebusy);
        int lat;
        int bcnt;
        run_div(av, bv, lat, bcnt);
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_busy"}, 32'(bcnt), 32'(ebusy));
        chk({tag, "_q"}, 32'(q), 32'(eq));
        chk({tag, "_r"}, 32'(r), 32'(er));
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'(0));
    endtask

    initial begin
        int lat;
        int dcnt;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #2;
        chk("rst_q", 32'(q), 32'(0));
        chk("rst_r", 32'(r), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
`ifdef DIV_BY_ZERO_FLAG_EN
        chk("rst_dz", 32'(div_zero), 32'(0));
`endif
        tick();
        tick();
        rst_n = 1'b1;

        // First edge after release must accept the start.
        check_div("basic", 16'd100, 16'd7, 16'd14, 16'd2, 16, 16);
        check_div("ffff_div_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 16, 16);
        check_div("5_div_9", 16'd5, 16'd9, 16'd0, 16'd5, 16, 16);
        check_div("ffff_div_ffff", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 16, 16);
        check_div("1000_div_37", 16'd1000, 16'd37, 16'd27, 16'd1, 16, 16);

        check_div("div0", 16'h1234, 16'd0, 16'hFFFF, 16'h1234, ZLAT, ZBUSY);
`ifdef DIV_BY_ZERO_FLAG_EN
        chk("div0_flag", 32'(div_zero), 32'(1));
        a = 16'd9;
        b = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("dz_clear_on_start", 32'(div_zero), 32'(0));
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("after_dz_lat", 32'(lat), 32'(16));
        chk("after_dz_q", 32'(q), 32'(3));
        tick();
`endif

        // Start while busy is ignored.
        a = 16'd100;
        b = 16'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        a = 16'd9;
        b = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int i = 6; i <= 40; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("busy_start_lat", 32'(lat), 32'(16));
        chk("busy_start_q", 32'(q), 32'(14));
        chk("busy_start_r", 32'(r), 32'(2));
        tick();
        chk("busy_start_idle", 32'(busy), 32'(0));

        // Back-to-back: start held high through DONE.
        a = 16'd50;
        b = 16'd6;
        start = 1'b1;
        tick();
        a = 16'd81;
        b = 16'd9;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("b2b_first_lat", 32'(lat), 32'(16));
        chk("b2b_first_q", 32'(q), 32'(8));
        chk("b2b_first_r", 32'(r), 32'(2));
        tick();
        start = 1'b0;
        chk("b2b_rerun_busy", 32'(busy), 32'(1));
        chk("b2b_done_one_cycle", 32'(done), 32'(0));
        lat = -1;
        for (int i = 2; i <= 40; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("b2b_second_lat", 32'(lat), 32'(17));
        chk("b2b_second_q", 32'(q), 32'(9));
        chk("b2b_second_r", 32'(r), 32'(0));
        tick();

        // Reset 8 cycles into a run.
        a = 16'd100;
        b = 16'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("mid_busy", 32'(busy), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_q", 32'(q), 32'(0));
        chk("mid_rst_r", 32'(r), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_done", 32'(done), 32'(0));
        tick();
        tick();
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) dcnt++;
        end
        chk("mid_rst_no_done", 32'(dcnt), 32'(0));
        check_div("post_rst", 16'd81, 16'd9, 16'd9, 16'd0, 16, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
